// File: rtl/serial_full_subtractor_if.sv
`default_nettype none
// ============================================================================
//  Module   : serial_full_subtractor_if
//  Purpose  : Operand / result valid-ready bundle for the bit-serial subtractor.
//             OVF exists only when SERIAL_SUB_OVF_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface serial_full_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             B_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             B_out;
`ifdef SERIAL_SUB_OVF_EN
    logic             OVF;
`endif

    modport master (
        output in_valid, A, B, B_in, out_ready,
        input  in_ready, out_valid, D, B_out
`ifdef SERIAL_SUB_OVF_EN
        , input OVF
`endif
    );

    modport slave (
        input  in_valid, A, B, B_in, out_ready,
        output in_ready, out_valid, D, B_out
`ifdef SERIAL_SUB_OVF_EN
        , output OVF
`endif
    );
endinterface
`default_nettype wire

// File: rtl/serial_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_full_subtractor
//  Purpose  : One-bit-per-clock WIDTH-bit subtractor (A - B - B_in), LSB first.
//             Optional signed overflow flag under macro SERIAL_SUB_OVF_EN.
//  Revision : 1.0  initial release
// ============================================================================
module serial_full_subtractor #(
    parameter int WIDTH = 8
) (
    input wire logic               clk,
    input wire logic               rst,
    serial_full_subtractor_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state_q,     w_state_d;
    logic [WIDTH-1:0]   r_a_q,         w_a_d;
    logic [WIDTH-1:0]   r_b_q,         w_b_d;
    logic [WIDTH-1:0]   r_d_q,         w_d_d;
    logic [CNT_W-1:0]   r_cnt_q,       w_cnt_d;
    logic               r_borrow_q,    w_borrow_d;
    logic               r_bout_q,      w_bout_d;
    logic               r_in_ready_q,  w_in_ready_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic               r_ovf_q,       w_ovf_d;

    logic               w_a_bit;
    logic               w_b_bit;
    logic               w_diff;
    logic               w_cell_bout;

    // Operands shift right, so bit 0 always holds the bit at index r_cnt_q.
    assign w_a_bit     = r_a_q[0];
    assign w_b_bit     = r_b_q[0];
    assign w_diff      = w_a_bit ^ w_b_bit ^ r_borrow_q;
    assign w_cell_bout = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_borrow_q);

    always_comb begin
        w_state_d  = r_state_q;
        w_a_d      = r_a_q;
        w_b_d      = r_b_q;
        w_d_d      = r_d_q;
        w_cnt_d    = r_cnt_q;
        w_borrow_d = r_borrow_q;
        w_bout_d   = r_bout_q;
        w_ovf_d    = r_ovf_q;

        case (r_state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    w_a_d      = bus.A;
                    w_b_d      = bus.B;
                    w_borrow_d = bus.B_in;
                    w_cnt_d    = '0;
                    w_state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_a_d          = r_a_q >> 1;
                w_b_d          = r_b_q >> 1;
                w_d_d[r_cnt_q] = w_diff;
                w_borrow_d     = w_cell_bout;
                w_cnt_d        = r_cnt_q + CNT_W'(1);
                if (r_cnt_q == CNT_W'(WIDTH - 1)) begin
                    w_cnt_d   = '0;
                    w_bout_d  = w_cell_bout;
                    // On the last cycle bit 0 of each operand register is its MSB.
                    w_ovf_d   = (w_a_bit != w_b_bit) && (w_diff != w_a_bit);
                    w_state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    w_state_d = S_IDLE;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        w_in_ready_d  = (w_state_d == S_IDLE);
        w_out_valid_d = (w_state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q     <= S_IDLE;
            r_a_q         <= '0;
            r_b_q         <= '0;
            r_d_q         <= '0;
            r_cnt_q       <= '0;
            r_borrow_q    <= 1'b0;
            r_bout_q      <= 1'b0;
            r_ovf_q       <= 1'b0;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_a_q         <= w_a_d;
            r_b_q         <= w_b_d;
            r_d_q         <= w_d_d;
            r_cnt_q       <= w_cnt_d;
            r_borrow_q    <= w_borrow_d;
            r_bout_q      <= w_bout_d;
            r_ovf_q       <= w_ovf_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
        end
    end

    assign bus.in_ready  = r_in_ready_q;
    assign bus.out_valid = r_out_valid_q;
    assign bus.D         = r_d_q;
    assign bus.B_out     = r_bout_q;

`ifdef SERIAL_SUB_OVF_EN
    assign bus.OVF = r_ovf_q;
`else
    logic w_ovf_unused;
    assign w_ovf_unused = r_ovf_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_serial_full_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_full_subtractor
//  Purpose  : Directed self-checking bench for serial_full_subtractor, WIDTH=8.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_full_subtractor;
    localparam int WIDTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    serial_full_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_full_subtractor #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) for out_valid and returns the cycle count since accept.
    task automatic wait_result(output int n);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic bin, input logic [7:0] exp_d, input logic exp_bo,
                          input logic exp_ovf);
        int n;
        check({tag, "_in_ready_idle"}, {31'd0, bus.in_ready}, 32'd1);
        bus.A        = a;
        bus.B        = b;
        bus.B_in     = bin;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        bus.A        = ~a;
        bus.B        = ~b;
        bus.B_in     = ~bin;
        check({tag, "_in_ready_busy"}, {31'd0, bus.in_ready}, 32'd0);
        wait_result(n);
        check({tag, "_latency"}, n, 32'd8);
        check({tag, "_D"}, {24'd0, bus.D}, {24'd0, exp_d});
        check({tag, "_B_out"}, {31'd0, bus.B_out}, {31'd0, exp_bo});
`ifdef SERIAL_SUB_OVF_EN
        check({tag, "_OVF"}, {31'd0, bus.OVF}, {31'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $display("note: unexpected X in expected OVF");
`endif
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_out_valid_drop"}, {31'd0, bus.out_valid}, 32'd0);
    endtask

    initial begin
        int n;
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.B_in      = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_D", {24'd0, bus.D}, 32'd0);
        check("rst_B_out", {31'd0, bus.B_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_OVF", {31'd0, bus.OVF}, 32'd0);
`endif

        run_op("v05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run_op("v03_05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run_op("v00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("vFF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        run_op("v80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("v7F_FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op("v10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0);

        // Backpressure, ignored second request during SHIFT, no accept in DONE.
        bus.A        = 8'h20;
        bus.B        = 8'h07;
        bus.B_in     = 1'b0;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        bus.A        = 8'h01;
        bus.B        = 8'h02;
        bus.B_in     = 1'b0;
        bus.in_valid = 1'b1;
        wait_result(n);
        check("bp_latency", n, 32'd6);
        check("bp_D", {24'd0, bus.D}, 32'h19);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            check("bp_hold_D", {24'd0, bus.D}, 32'h19);
            check("bp_hold_B_out", {31'd0, bus.B_out}, 32'd0);
            check("bp_hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check("bp_release_valid", {31'd0, bus.out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, bus.in_ready}, 32'd0);
        wait_result(n);
        check("bp_second_latency", n, 32'd8);
        check("bp_second_D", {24'd0, bus.D}, 32'hFF);
        check("bp_second_B_out", {31'd0, bus.B_out}, 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Reset mid-SHIFT with a borrow chain in flight.
        bus.A        = 8'h00;
        bus.B        = 8'h01;
        bus.B_in     = 1'b1;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrst_D", {24'd0, bus.D}, 32'd0);
        check("midrst_B_out", {31'd0, bus.B_out}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("midrst_no_result", {31'd0, bus.out_valid}, 32'd0);
        end
        run_op("post_rst", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/serial_full_subtractor.md
# serial_full_subtractor

Bit-serial N-bit subtractor built around a single full-subtractor cell (D = A ^ B ^ Bin, Bout = (~A & B) | (~(A ^ B) & Bin)), the inverse counterpart of the gate-level full adder. It accepts two WIDTH-bit operands and a borrow-in through a valid/ready handshake, and processes one bit per clock, LSB first. It returns the difference and the final borrow through a second valid/ready handshake. It sits beside the adder in the arithmetic library as the area-minimal subtract path.

## Interface
- WIDTH, 8, operand and result width in bits (legal range 2..32)
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands A, B, B_in are valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- A  input  WIDTH  minuend
- B  input  WIDTH  subtrahend
- B_in  input  1  borrow-in applied to bit 0
- out_valid  output  1  D, B_out (and OVF) are valid
- out_ready  input  1  consumer accepts result
- D  output  WIDTH  difference A - B - B_in, modulo 2^WIDTH
- B_out  output  1  borrow out of the MSB (1 when unsigned A < B + B_in)
- OVF  output  1  signed overflow flag (present only with SERIAL_SUB_OVF_EN)

## Operation
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch A, B, B_in into shift registers, clear bit counter to 0, go to SHIFT.
- SHIFT:
  - Each cycle the cell consumes bit[cnt] of A and B plus the registered borrow.
  - It writes the difference bit into D[cnt] and registers Bout as the next borrow.
  - cnt increments by 1.
  - When cnt == WIDTH-1 is processed, go to DONE.
  - in_ready=0. in_valid is ignored.
- DONE:
  - out_valid=1. D, B_out and OVF are held stable.
  - On out_ready, return to IDLE and drop out_valid.
  - If out_ready stays low, hold indefinitely (backpressure). Outputs do not change.
- Arithmetic is unsigned modulo 2^WIDTH. B_out is the borrow out of bit WIDTH-1. No sign extension.
- Operand inputs are sampled only at the accept edge. Changes on A, B, B_in during SHIFT/DONE have no effect.
- No new operand is accepted in DONE, even if out_ready and in_valid are both high in the same cycle. Accept is possible one cycle later, in IDLE.

## Timing
- Reset values, applied at any rising edge with rst=1 regardless of state:
  - state=IDLE, in_ready=1 after reset, out_valid=0.
  - D=0, B_out=0, OVF=0, counter=0, internal borrow=0.
- Reset mid-SHIFT or mid-DONE aborts the operation. No result is ever presented for it.
- Latency: operands accepted at edge k, then out_valid=1 after edge k+WIDTH. The SHIFT state lasts exactly WIDTH cycles.
- Minimum issue interval: WIDTH+2 cycles (accept, WIDTH shift cycles, 1 DONE cycle with out_ready=1, back in IDLE).
- All outputs are registered. No combinational path from any input to any output except none (in_ready depends on state only).

## Configuration
- SERIAL_SUB_OVF_EN defined:
  - OVF port exists.
  - OVF = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]), computed on the final SHIFT cycle and held in DONE.
  - Reset value of OVF is 0.
- SERIAL_SUB_OVF_EN undefined: OVF port and its logic are absent. All other behaviour is identical.

## Test plan
All cases use WIDTH=8.
- A=0x05, B=0x03, B_in=0 -> D=0x02, B_out=0, out_valid exactly 8 cycles after accept.
- A=0x03, B=0x05, B_in=0 -> D=0xFE, B_out=1.
- A=0x00, B=0x00, B_in=1 -> D=0xFF, B_out=1. Also A=0xFF, B=0xFF, B_in=0 -> D=0x00, B_out=0.
- A=0x80, B=0x01 (OVF_EN build) -> D=0x7F, B_out=0, OVF=1. A=0x7F, B=0xFF -> D=0x80, B_out=1, OVF=1. A=0x10, B=0x01 -> OVF=0.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> D/B_out stable, in_ready=0.
  - Second in_valid during SHIFT is ignored.
  - Assert out_ready -> IDLE next cycle, then the second operand pair is accepted.
- Reset mid-SHIFT (rst at bit 4):
  - Next cycle in_ready=1, out_valid=0, D=0.
  - A fresh 0x05-0x03 then yields 0x02 with no stale borrow.
